// File: rtl/lpm_tbl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : lpm_tbl_pkg
// Purpose : Shared types and constants for the LPM route-table controller.
//           Holds the controller state encoding, the route-entry width and
//           the bit offsets of the fields packed into one 128-bit entry.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
package lpm_tbl_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } tbl_state_e;

  // One route entry is four 32-bit words.
  localparam int TBL_ENTRY_WIDTH = 128;
  localparam int ENT_FIELD_WIDTH = 32;

  // Field LSB offsets inside an entry.
  localparam int ENT_IP_LSB      = 0;
  localparam int ENT_MASK_LSB    = 32;
  localparam int ENT_NEXTHOP_LSB = 64;
  localparam int ENT_OUTQ_LSB    = 96;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lpm_tbl_ctrl_rr_arb2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Purpose : Two-way round-robin arbiter. When both requests are present the
//           grant goes to the pointer; otherwise to whichever is requesting.
//           The pointer moves to the other requester when upd_i is pulsed.
// Ports   : clk, reset      - clock, synchronous active-high reset
//           en_i            - grants allowed this cycle
//           req_i[1:0]      - request vector
//           upd_i, upd_id_i - pointer update strobe / id just served
//           gnt_o[1:0]      - one-hot grant (combinational)
//           gnt_id_o        - index of the granted requester
// Rev     : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_id_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) begin
      ptr_d = ~upd_id_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // With at most one request present the request vector is already one-hot.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (&req_i) begin
        gnt_o = ptr_q ? 2'b10 : 2'b01;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  assign gnt_id_o = gnt_o[1];

endmodule
`default_nettype wire

// File: rtl/lpm_tbl_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : lpm_tbl_ctrl
// Purpose : Shares the LPM route table between the host register interface
//           (requester 0) and the route-install engine (requester 1). Each
//           accepted command becomes one table read/write pulse, the matching
//           ack is awaited with a timeout, and the result is returned to the
//           requester that issued it. Writes wait while the lookup datapath is
//           inside its header window so an entry never changes mid-lookup.
// Ports   : clk, reset                      - clock, sync active-high reset
//           req_valid/ready/wr/addr/wdata_N - command channel, requester N
//           rsp_valid/rdata/err_N           - one-cycle response, requester N
//           tbl_rd_req/addr, tbl_rd_data/ack - table read port
//           tbl_wr_req/addr/data, tbl_wr_ack - table write port
//           lookup_busy                     - lookup header window active
//           busy                            - an op is in flight
//           timeout_count                   - saturating timed-out op count
// Rev     : 1.0 - initial release
// ============================================================================
module lpm_tbl_ctrl
  import lpm_tbl_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int TBL_ADDR_WIDTH     = 5,
  parameter int ACK_TIMEOUT        = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid_0,
  output logic                            req_ready_0,
  input  logic                            req_wr_0,
  input  logic [TBL_ADDR_WIDTH-1:0]       req_addr_0,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0] req_wdata_0,
  output logic                            rsp_valid_0,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] rsp_rdata_0,
  output logic                            rsp_err_0,
  input  logic                            req_valid_1,
  output logic                            req_ready_1,
  input  logic                            req_wr_1,
  input  logic [TBL_ADDR_WIDTH-1:0]       req_addr_1,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0] req_wdata_1,
  output logic                            rsp_valid_1,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] rsp_rdata_1,
  output logic                            rsp_err_1,
  output logic                            tbl_rd_req,
  output logic                            tbl_wr_req,
  output logic [TBL_ADDR_WIDTH-1:0]       tbl_rd_addr,
  output logic [TBL_ADDR_WIDTH-1:0]       tbl_wr_addr,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
  input  logic                            tbl_rd_ack,
  input  logic                            tbl_wr_ack,
  input  logic                            lookup_busy,
  output logic                            busy,
  output logic [31:0]                     timeout_count
);

  localparam int         W             = 4 * C_S_AXI_DATA_WIDTH;
  localparam logic [7:0] C_ACK_TIMEOUT = 8'(ACK_TIMEOUT);

  tbl_state_e                state_q;
  logic                      wr_q;
  logic                      gnt_id_q;
  logic                      err_q;
  logic [TBL_ADDR_WIDTH-1:0] addr_q;
  logic [TBL_ADDR_WIDTH-1:0] rd_addr_q;
  logic [TBL_ADDR_WIDTH-1:0] wr_addr_q;
  logic [W-1:0]              wdata_q;
  logic [W-1:0]              wr_data_q;
  logic [W-1:0]              rdata_q;
  logic [7:0]                wcnt_q;
  logic [31:0]               timeout_count_q;
  logic [31:0]               timeout_count_d;

  logic [1:0]                gnt;
  logic                      gnt_id;
  logic                      accept;
  logic                      issue_go;
  logic                      ack_match;
  logic [7:0]                wcnt_inc;
  logic                      tmo_hit;

  // Reset is folded into the enable so no command is acknowledged while the
  // block is being reset.
  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .en_i     ((state_q == ST_IDLE) && !reset),
    .req_i    ({req_valid_1, req_valid_0}),
    .upd_i    (state_q == ST_RESP),
    .upd_id_i (gnt_id_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign accept    = |gnt;
  assign issue_go  = (state_q == ST_ISSUE) && !(wr_q && lookup_busy);
  assign ack_match = wr_q ? tbl_wr_ack : tbl_rd_ack;
  assign wcnt_inc  = wcnt_q + 8'd1;
  // The ack wins if it lands in the same cycle the count expires.
  assign tmo_hit   = !ack_match && (wcnt_inc == C_ACK_TIMEOUT);

  always_comb begin
    timeout_count_d = timeout_count_q;
    if ((state_q == ST_WAIT) && tmo_hit) begin
      timeout_count_d = sat_inc32(timeout_count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      wr_q            <= 1'b0;
      gnt_id_q        <= 1'b0;
      err_q           <= 1'b0;
      addr_q          <= '0;
      rd_addr_q       <= '0;
      wr_addr_q       <= '0;
      wdata_q         <= '0;
      wr_data_q       <= '0;
      rdata_q         <= '0;
      wcnt_q          <= '0;
      timeout_count_q <= '0;
    end else begin
      timeout_count_q <= timeout_count_d;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            wr_q     <= gnt_id ? req_wr_1    : req_wr_0;
            addr_q   <= gnt_id ? req_addr_1  : req_addr_0;
            wdata_q  <= gnt_id ? req_wdata_1 : req_wdata_0;
            gnt_id_q <= gnt_id;
            // Writes respond with zero data.
            rdata_q  <= '0;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issue_go) begin
            // Capture what was presented so the table port holds it.
            if (wr_q) begin
              wr_addr_q <= addr_q;
              wr_data_q <= wdata_q;
            end else begin
              rd_addr_q <= addr_q;
            end
            wcnt_q  <= '0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          wcnt_q <= wcnt_inc;
          if (ack_match) begin
            if (!wr_q) begin
              rdata_q <= tbl_rd_data;
            end
            err_q   <= 1'b0;
            state_q <= ST_RESP;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready_0 = gnt[0];
  assign req_ready_1 = gnt[1];

  assign tbl_rd_req  = (state_q == ST_ISSUE) && !wr_q;
  assign tbl_wr_req  = issue_go && wr_q;
  assign tbl_rd_addr = tbl_rd_req ? addr_q  : rd_addr_q;
  assign tbl_wr_addr = tbl_wr_req ? addr_q  : wr_addr_q;
  assign tbl_wr_data = tbl_wr_req ? wdata_q : wr_data_q;

  assign rsp_valid_0 = (state_q == ST_RESP) && !gnt_id_q;
  assign rsp_valid_1 = (state_q == ST_RESP) &&  gnt_id_q;
  assign rsp_rdata_0 = rsp_valid_0 ? rdata_q : '0;
  assign rsp_rdata_1 = rsp_valid_1 ? rdata_q : '0;
  assign rsp_err_0   = rsp_valid_0 && err_q;
  assign rsp_err_1   = rsp_valid_1 && err_q;

  assign busy          = (state_q != ST_IDLE);
  assign timeout_count = timeout_count_q;

endmodule
`default_nettype wire

// File: tb/tb_lpm_tbl_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_lpm_tbl_ctrl
// Purpose : Directed scoreboard bench for lpm_tbl_ctrl. Drivers push the
//           expected response when a command is accepted; a monitor pops and
//           compares whenever a response pulse appears. A table model records
//           every table request for per-test checks.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_lpm_tbl_ctrl;

  localparam int AW = 5;
  localparam int W  = 128;

  localparam logic [W-1:0] VA   = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
  localparam logic [W-1:0] V2   = 128'h10000002_10000002_10000002_10000002;
  localparam logic [W-1:0] WD1  = 128'h0000000A_00000003_FFFF0000_0A010000;
  localparam logic [W-1:0] WD31 = 128'hDEADBEEF_00000031_FFFFFF00_C0A80100;
  localparam logic [W-1:0] WD3  = 128'h33333333_44444444_55555555_66666666;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid_0, req_ready_0, req_wr_0, rsp_valid_0, rsp_err_0;
  logic [AW-1:0] req_addr_0;
  logic [W-1:0]  req_wdata_0, rsp_rdata_0;
  logic          req_valid_1, req_ready_1, req_wr_1, rsp_valid_1, rsp_err_1;
  logic [AW-1:0] req_addr_1;
  logic [W-1:0]  req_wdata_1, rsp_rdata_1;
  logic          tbl_rd_req, tbl_wr_req, tbl_rd_ack, tbl_wr_ack, lookup_busy, busy;
  logic [AW-1:0] tbl_rd_addr, tbl_wr_addr;
  logic [W-1:0]  tbl_wr_data, tbl_rd_data;
  logic [31:0]   timeout_count;

  lpm_tbl_ctrl #(.C_S_AXI_DATA_WIDTH(32), .TBL_ADDR_WIDTH(AW), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_wr_0(req_wr_0),
    .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
    .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0), .rsp_err_0(rsp_err_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_wr_1(req_wr_1),
    .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
    .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1), .rsp_err_1(rsp_err_1),
    .tbl_rd_req(tbl_rd_req), .tbl_wr_req(tbl_wr_req),
    .tbl_rd_addr(tbl_rd_addr), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
    .tbl_rd_data(tbl_rd_data), .tbl_rd_ack(tbl_rd_ack), .tbl_wr_ack(tbl_wr_ack),
    .lookup_busy(lookup_busy), .busy(busy), .timeout_count(timeout_count)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int           port;
    logic [W-1:0] rdata;
    logic         err;
    int           exp_cyc;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    int            c;
  } tev_t;
  tev_t tq[$];

  logic [W-1:0] mem [32];
  bit ack_en   = 1'b1;
  int ack_dly  = 1;
  bit stray_wr = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_ctl"}, W'({req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_err_0,
                          rsp_err_1, tbl_rd_req, tbl_wr_req, busy, tbl_rd_addr, tbl_wr_addr}), '0);
    chk({nm, "_data"}, rsp_rdata_0 | rsp_rdata_1 | tbl_wr_data, '0);
    chk({nm, "_tmo"}, W'(timeout_count), '0);
  endtask

  task automatic chk_tev(input string nm, input logic wr, input logic [AW-1:0] a,
                         input logic [W-1:0] d, input int c);
    tev_t t;
    if (tq.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no table request seen, expected one at cycle %0d", nm, c);
    end else begin
      t = tq.pop_front();
      chk({nm, "_kind"}, W'(t.wr), W'(wr));
      chk({nm, "_addr"}, W'(t.addr), W'(a));
      chk({nm, "_cycle"}, W'(t.c), W'(c));
      if (wr) chk({nm, "_data"}, t.data, d);
    end
  endtask

  // Issue one command from requester n; returns the accept cycle.
  task automatic drive(input int n, input logic wr, input logic [AW-1:0] a, input logic [W-1:0] wd,
                       input logic [W-1:0] er, input logic ee, input int lat, input bit exp_rsp,
                       output int acc);
    int k;
    k = 0;
    acc = -1;
    if (n == 0) begin
      req_wr_0 = wr; req_addr_0 = a; req_wdata_0 = wd; req_valid_0 = 1'b1;
    end else begin
      req_wr_1 = wr; req_addr_1 = a; req_wdata_1 = wd; req_valid_1 = 1'b1;
    end
    #1;
    while (!((n == 0) ? req_ready_0 : req_ready_1) && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    if (k >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_wait_req%0d: not accepted within 100 cycles", n);
    end else begin
      acc = cyc;
      if (exp_rsp) sbq.push_back('{port: n, rdata: er, err: ee, exp_cyc: (lat > 0) ? acc + lat : -1});
    end
    @(negedge clk);
    // Scramble the command bus: the DUT must have latched it at accept.
    if (n == 0) begin
      req_valid_0 = 1'b0; req_wr_0 = ~wr; req_addr_0 = ~a; req_wdata_0 = ~wd;
    end else begin
      req_valid_1 = 1'b0; req_wr_1 = ~wr; req_addr_1 = ~a; req_wdata_1 = ~wd;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((sbq.size() != 0 || busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_wait: busy=%0b pending=%0d after 200 cycles", busy, sbq.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Table model: acks ack_dly cycles after a request, optional stray write ack.
  initial begin
    bit rp, wp;
    int rc, wc, sc;
    logic [AW-1:0] ra;
    rp = 1'b0; wp = 1'b0; rc = 0; wc = 0; sc = 0; ra = '0;
    tbl_rd_ack = 1'b0; tbl_wr_ack = 1'b0; tbl_rd_data = '0;
    forever begin
      @(negedge clk);
      tbl_rd_ack = 1'b0;
      tbl_wr_ack = 1'b0;
      if (reset) begin rp = 1'b0; wp = 1'b0; sc = 0; end
      if (rp) begin rc--; if (rc == 0) begin tbl_rd_ack = 1'b1; tbl_rd_data = mem[ra]; rp = 1'b0; end end
      if (wp) begin wc--; if (wc == 0) begin tbl_wr_ack = 1'b1; wp = 1'b0; end end
      if (sc > 0) begin sc--; if (sc == 0) tbl_wr_ack = 1'b1; end
      #2;
      if (tbl_rd_req || tbl_wr_req) chk("single_tbl_req", W'(tbl_rd_req & tbl_wr_req), '0);
      if (tbl_rd_req) begin
        tq.push_back('{wr: 1'b0, addr: tbl_rd_addr, data: '0, c: cyc});
        if (ack_en) begin rp = 1'b1; rc = ack_dly; ra = tbl_rd_addr; end
        if (stray_wr) sc = 1;
      end
      if (tbl_wr_req) begin
        tq.push_back('{wr: 1'b1, addr: tbl_wr_addr, data: tbl_wr_data, c: cyc});
        mem[tbl_wr_addr] = tbl_wr_data;
        if (ack_en) begin wp = 1'b1; wc = ack_dly; end
      end
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    int   p;
    forever begin
      @(negedge clk); #1;
      if (rsp_valid_0 || rsp_valid_1) begin
        if (rsp_valid_0 && rsp_valid_1) begin
          chk("rsp_one_port", W'(rsp_valid_0 & rsp_valid_1), '0);
        end else if (sbq.size() == 0) begin
          chk("rsp_unexpected", W'({rsp_valid_1, rsp_valid_0}), '0);
        end else begin
          e = sbq.pop_front();
          p = rsp_valid_1 ? 1 : 0;
          chk("rsp_port", W'(p), W'(e.port));
          chk("rsp_rdata", (p == 1) ? rsp_rdata_1 : rsp_rdata_0, e.rdata);
          chk("rsp_err", W'((p == 1) ? rsp_err_1 : rsp_err_0), W'(e.err));
          chk("rsp_other_quiet", W'((p == 1) ? ((|rsp_rdata_0) | rsp_err_0) : ((|rsp_rdata_1) | rsp_err_1)), '0);
          if (e.exp_cyc >= 0) chk("rsp_cycle", W'(cyc), W'(e.exp_cyc));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, a0b, a1;
    for (int i = 0; i < 32; i++) mem[i] = {4{32'h1000_0000 + 32'(i)}};
    mem[5] = VA;
    req_valid_0 = 1'b0; req_wr_0 = 1'b0; req_addr_0 = '0; req_wdata_0 = '0;
    req_valid_1 = 1'b0; req_wr_1 = 1'b0; req_addr_1 = '0; req_wdata_1 = '0;
    lookup_busy = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset_state");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Contention: req0 twice, req1 once, all valid together.
    tq.delete();
    fork
      begin
        drive(0, 1'b1, 5'd1, WD1, '0, 1'b0, 3, 1'b1, a0);
        drive(0, 1'b0, 5'd1, '0, WD1, 1'b0, 3, 1'b1, a0b);
      end
      drive(1, 1'b0, 5'd2, '0, V2, 1'b0, 3, 1'b1, a1);
    join
    wait_idle();
    chk("cont_req1_second", W'(a1), W'(a0 + 4));
    chk("cont_req0_third", W'(a0b), W'(a0 + 8));
    chk("cont_tbl_count", W'(tq.size()), W'(3));
    chk_tev("cont_wr1", 1'b1, 5'd1, WD1, a0 + 1);
    chk_tev("cont_rd2", 1'b0, 5'd2, '0, a0 + 5);
    chk_tev("cont_rd1", 1'b0, 5'd1, '0, a0 + 9);

    // Uncontended read of index 5.
    tq.delete();
    drive(0, 1'b0, 5'd5, '0, VA, 1'b0, 3, 1'b1, a0);
    wait_idle();
    chk("rd5_tbl_count", W'(tq.size()), W'(1));
    chk_tev("rd5", 1'b0, 5'd5, '0, a0 + 1);

    // Write hold-off: lookup_busy high for 6 cycles from accept.
    tq.delete();
    fork
      begin
        lookup_busy = 1'b1;
        repeat (6) @(negedge clk);
        lookup_busy = 1'b0;
      end
      drive(1, 1'b1, 5'd31, WD31, '0, 1'b0, 8, 1'b1, a1);
    join
    wait_idle();
    chk("hold_tbl_count", W'(tq.size()), W'(1));
    chk_tev("hold_wr31", 1'b1, 5'd31, WD31, a1 + 6);

    // Timeout, then saturation from a forced all-ones count.
    tq.delete();
    ack_en = 1'b0;
    drive(0, 1'b1, 5'd3, WD3, '0, 1'b1, 18, 1'b1, a0);
    wait_idle();
    chk("tmo_count_1", W'(timeout_count), W'(32'd1));
    force dut.timeout_count_q = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    release dut.timeout_count_q;
    drive(0, 1'b1, 5'd3, WD3, '0, 1'b1, 18, 1'b1, a0);
    wait_idle();
    chk("tmo_count_sat", W'(timeout_count), W'(32'hFFFF_FFFF));
    chk("tmo_tbl_count", W'(tq.size()), W'(2));

    // Reset while waiting on an ack that never comes.
    tq.delete();
    drive(0, 1'b0, 5'd6, '0, '0, 1'b0, 0, 1'b0, a0);
    repeat (2) @(negedge clk);
    chk("rst_mid_in_wait", W'(busy), W'(1'b1));
    reset = 1'b1;
    @(negedge clk); #1;
    check_all_zero("rst_mid");
    reset = 1'b0;
    ack_en = 1'b1;
    repeat (24) @(negedge clk);
    fork
      drive(1, 1'b0, 5'd31, '0, WD31, 1'b0, 3, 1'b1, a1);
      drive(0, 1'b0, 5'd5, '0, VA, 1'b0, 3, 1'b1, a0);
    join
    wait_idle();
    chk("rst_ptr_req1_after_req0", W'(a1), W'(a0 + 4));

    // Stray write ack during a read wait.
    tq.delete();
    ack_dly = 3;
    stray_wr = 1'b1;
    drive(0, 1'b0, 5'd2, '0, V2, 1'b0, 5, 1'b1, a0);
    wait_idle();
    stray_wr = 1'b0;
    ack_dly = 1;
    chk_tev("stray_rd2", 1'b0, 5'd2, '0, a0 + 1);

    chk("scoreboard_drained", W'(sbq.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lpm_tbl_ctrl.md
# lpm_tbl_ctrl

Sequences and shares the 32-entry LPM route table between two requesters: the host register interface (requester 0) and the route-install engine (requester 1). Each accepted request is turned into a single-cycle `tbl_rd_req` or `tbl_wr_req` pulse toward the LPM lookup block's table port, and the block waits for the matching ack, with a timeout. The result is returned to the originating requester. Writes are held off while the lookup datapath is evaluating a header, so a route entry never changes mid-lookup.

## Interface

Clock is `clk`. Reset is `reset`: synchronous, active-high.

**Parameters**

- `C_S_AXI_DATA_WIDTH`, 32: register word width; a table entry is 4 words (128 b).
- `TBL_ADDR_WIDTH`, 5: table index width (32 entries).
- `ACK_TIMEOUT`, 16: cycles to wait for an ack before declaring an error; legal range 2–255.

**Ports** (`N` = 0 or 1 is the requester; W = 4*`C_S_AXI_DATA_WIDTH`)

- `clk` in 1: clock.
- `reset` in 1: synchronous active-high reset.
- `req_valid_N` in 1: requester N has a command.
- `req_ready_N` out 1: command accepted this cycle when `valid & ready`.
- `req_wr_N` in 1: 1 = write, 0 = read.
- `req_addr_N` in `TBL_ADDR_WIDTH`: table index.
- `req_wdata_N` in W: entry to write.
- `rsp_valid_N` out 1: one-cycle completion pulse; no backpressure.
- `rsp_rdata_N` out W: read data, valid with `rsp_valid_N`.
- `rsp_err_N` out 1: the op timed out; valid with `rsp_valid_N`.
- `tbl_rd_req` out 1: read request to the table, one-cycle pulse.
- `tbl_wr_req` out 1: write request to the table, one-cycle pulse.
- `tbl_rd_addr` out `TBL_ADDR_WIDTH`: read index.
- `tbl_wr_addr` out `TBL_ADDR_WIDTH`: write index.
- `tbl_wr_data` out W: write entry.
- `tbl_rd_data` in W: read entry, valid with `tbl_rd_ack`.
- `tbl_rd_ack` in 1: read done.
- `tbl_wr_ack` in 1: write done.
- `lookup_busy` in 1: the lookup is in its header window; writes must stall.
- `busy` out 1: an op is in flight (state ≠ IDLE).
- `timeout_count` out 32: saturating count of timed-out ops.

## Operation

**Reset values**

- All outputs are 0.
- State is IDLE; RR pointer = 0.
- An op in flight at reset is discarded and produces no response.

**States**

- **IDLE**
  - `req_ready` goes high combinationally to one requester only.
  - If both are valid, the grant goes to the RR pointer; otherwise to whichever is valid.
  - On accept, latch `wr`, `addr`, `wdata`, and the grant; go to ISSUE.
- **ISSUE**
  - If the op is a write and `lookup_busy` = 1: stay, no table request.
  - Otherwise: assert exactly one of `tbl_rd_req` / `tbl_wr_req` for this one cycle, with address/data driven from the latches; clear the wait counter; go to WAIT.
- **WAIT**
  - Counter increments each cycle.
  - The matching ack (`tbl_rd_ack` for a read, `tbl_wr_ack` for a write) latches `tbl_rd_data` on reads, clears err, and goes to RESP.
  - When the counter reaches `ACK_TIMEOUT` with no ack: set err, `timeout_count` += 1 (saturating at 0xFFFFFFFF), go to RESP.
  - A non-matching ack is ignored.
- **RESP**
  - `rsp_valid`, `rsp_rdata` (0 for writes) and `rsp_err` are driven to the granted requester only.
  - RR pointer becomes the other requester.
  - Go to IDLE.

**Rules**

- `req_*` inputs are sampled only at accept; later changes are ignored.
- `tbl_*_addr` and `tbl_wr_data` hold their last values outside ISSUE; the table ignores them without a req.
- Reads are never held off by `lookup_busy`.

## Timing

- Uncontended read, with the ack one cycle after the req:
  - cycle 0: accept;
  - cycle 1: ISSUE, `tbl_rd_req` high;
  - cycle 2: ack arrives;
  - cycle 3: `rsp_valid` high.
- Accept-to-response is therefore 3 cycles.
- The next accept is possible in cycle 4 (IDLE), giving throughput of one op per 4 cycles.
- A write stalled by `lookup_busy` adds one cycle per busy cycle in ISSUE.
- Timeout response comes `ACK_TIMEOUT` + 2 cycles after accept.
- `req_ready` never rises outside IDLE.
- At most one table request is outstanding.

## Structure

- Package `lpm_tbl_pkg` holds:
  - state encoding (IDLE/ISSUE/WAIT/RESP);
  - `TBL_ENTRY_WIDTH` = 128;
  - entry field offsets: ip [31:0], mask [63:32], next hop [95:64], output queue [127:96].
- Sub-module `rr_arb2`: 2-way round-robin grant with a pointer-update input.

## Test plan

- **Uncontended read.** Req0 reads index 5, where 0xAAAA…(128b) is preloaded. Expect `tbl_rd_req` for 1 cycle at addr 5, `rsp_valid_0` 3 cycles after accept with `rsp_rdata_0` = that value, `rsp_err_0` = 0, and no `rsp_valid_1`.
- **Contention.** Both requesters are valid after reset; req0 writes index 1, req1 reads index 2. Expect req0 served first, then req1; the next simultaneous pair is served req1-then-req0.
- **Write hold-off.** `lookup_busy` is held high for 6 cycles while req1 writes index 31. Expect no `tbl_wr_req` during busy, then `tbl_wr_req` in the cycle after busy falls, with `tbl_wr_addr` = 31.
- **Timeout.** The table model never acks, `ACK_TIMEOUT` = 16. Expect `rsp_err` = 1 at accept + 18 and `timeout_count` = 1. Saturation check: force the counter to 0xFFFFFFFF and time out again; it stays 0xFFFFFFFF.
- **Reset mid-op.** Assert `reset` in WAIT. Expect no `rsp_valid`, all outputs 0 the next cycle, and the next request granted to req0.
- **Stray ack.** Inject `tbl_wr_ack` during a read WAIT. Expect it ignored; the real `tbl_rd_ack` completes the op normally.
